// File: rtl/rtc_lector.sv
// rtc_lector
//   Polls the RTC time/timer registers over its multiplexed address/data
//   bus, converts each BCD value to binary into a working buffer, and on a
//   completed sweep copies it to a shadow buffer. On every vblank rising
//   edge (once data is valid) it streams 3 pad bytes plus the 11 shadow
//   bytes, one per clock, to the VGA text interface.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   vblank              high outside the visible rows
//   ad_in / ad_out      RTC bus read side / drive side
//   ad_oe               bus drive enable (tristate built above)
//   cs_n rd_n wr_n ad_n active-low RTC strobes, ad_n low = address phase
//   datoRTC             burst byte (0..99, 8'hFF = invalid BCD)
//   inicioSecuencia     high for the 14 clocks of a burst
//   datos_validos       sticky after the first complete sweep
//   bcd_err             1-clock pulse at commit of a sweep with bad BCD
module rtc_lector #(
  parameter int T_PULSE     = 10,
  parameter int POLL_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] datoRTC,
  output logic       inicioSecuencia,
  output logic       datos_validos,
  output logic       bcd_err
);

  localparam logic [8:0]  TP          = 9'(T_PULSE);
  localparam logic [31:0] POLL_RELOAD = 32'(POLL_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX    = 4'd10;
  localparam logic [3:0]  LAST_BEAT   = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_COMMIT} state_e;

  state_e            state_q;
  logic [8:0]        ph_q;
  logic [3:0]        idx_q;
  logic [31:0]       poll_q;
  logic              err_q;
  logic [10:0][7:0]  work_q, shadow_q;
  logic [7:0]        ad_out_q;
  logic              ad_oe_q, cs_n_q, rd_n_q, wr_n_q, ad_n_q;
  logic              dv_q, bcd_err_q;

  logic              vb_q, busy_q, inicio_q;
  logic [3:0]        bcnt_q;
  logic [7:0]        dato_q;

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = 8'h21;
      4'd1:    addr_of = 8'h22;
      4'd2:    addr_of = 8'h23;
      4'd3:    addr_of = 8'h24;
      4'd4:    addr_of = 8'h25;
      4'd5:    addr_of = 8'h26;
      4'd6:    addr_of = 8'h27;
      4'd7:    addr_of = 8'h28;
      4'd8:    addr_of = 8'h41;
      4'd9:    addr_of = 8'h42;
      default: addr_of = 8'h43;
    endcase
  endfunction

  function automatic logic [7:0] mask_of(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd8, 4'd9: mask_of = 8'h7F;
      4'd4:                   mask_of = 8'h1F;
      4'd5:                   mask_of = 8'hFF;
      4'd6:                   mask_of = 8'h07;
      default:                mask_of = 8'h3F;
    endcase
  endfunction

  // BCD -> binary of the masked bus value for the current index
  logic [7:0] masked, conv_val;
  logic       conv_bad;
  always_comb begin
    masked   = ad_in & mask_of(idx_q);
    conv_bad = (masked[7:4] > 4'd9) || (masked[3:0] > 4'd9);
    conv_val = conv_bad ? 8'hFF
             : ({1'b0, masked[7:4], 3'b000} + {3'b000, masked[7:4], 1'b0}
                + {4'b0000, masked[3:0]});
  end

  // A vblank edge takes priority over a commit in the same clock. A commit
  // may still land on the final beat: that beat reads shadow[10] before the
  // copy takes effect, so the burst stays consistent.
  logic rise, start, commit_ok;
  assign rise      = vblank & ~vb_q;
  assign start     = rise & dv_q & ~busy_q;
  assign commit_ok = ~start & (~busy_q | (bcnt_q == LAST_BEAT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      idx_q     <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
      work_q    <= '0;
      shadow_q  <= '0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_n_q    <= 1'b1;
      dv_q      <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      bcd_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (poll_q == '0) begin
            state_q  <= S_ADDR;
            ph_q     <= '0;
            cs_n_q   <= 1'b0;
            ad_n_q   <= 1'b0;
            ad_oe_q  <= 1'b1;
            ad_out_q <= addr_of(idx_q);
          end else begin
            poll_q <= poll_q - 32'd1;
          end
        end
        S_ADDR: begin
          ph_q <= ph_q + 9'd1;
          if (ph_q == TP + 9'd2) begin
            state_q <= S_GAP;
          end else if (ph_q < TP) begin
            wr_n_q <= 1'b0;
          end else if (ph_q == TP) begin
            wr_n_q <= 1'b1;
          end else begin
            ad_oe_q  <= 1'b0;
            ad_n_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            ad_out_q <= '0;
          end
        end
        S_GAP: begin
          state_q <= S_DATA;
          ph_q    <= '0;
          cs_n_q  <= 1'b0;
        end
        S_DATA: begin
          ph_q <= ph_q + 9'd1;
          if (ph_q == TP + 9'd1) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_COMMIT;
            end else begin
              idx_q    <= idx_q + 4'd1;
              state_q  <= S_ADDR;
              ph_q     <= '0;
              cs_n_q   <= 1'b0;
              ad_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= addr_of(idx_q + 4'd1);
            end
          end else if (ph_q < TP) begin
            rd_n_q <= 1'b0;
          end else begin
            // last low clock of rd_n: capture the bus
            rd_n_q        <= 1'b1;
            cs_n_q        <= 1'b1;
            work_q[idx_q] <= conv_val;
            if (conv_bad) err_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (commit_ok) begin
            shadow_q  <= work_q;
            dv_q      <= 1'b1;
            bcd_err_q <= err_q;
            err_q     <= 1'b0;
            idx_q     <= '0;
            poll_q    <= POLL_RELOAD;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Burst: busy_q marks the 14 beats from the detecting edge; the outputs
  // follow one clock later, giving the 2-clock vblank-to-output latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q     <= 1'b0;
      busy_q   <= 1'b0;
      bcnt_q   <= '0;
      inicio_q <= 1'b0;
      dato_q   <= '0;
    end else begin
      vb_q <= vblank;
      if (start) begin
        busy_q   <= 1'b1;
        bcnt_q   <= '0;
        inicio_q <= 1'b0;
        dato_q   <= '0;
      end else if (busy_q) begin
        inicio_q <= 1'b1;
        dato_q   <= (bcnt_q < 4'd3) ? 8'h00 : shadow_q[bcnt_q - 4'd3];
        if (bcnt_q == LAST_BEAT) busy_q <= 1'b0;
        else                     bcnt_q <= bcnt_q + 4'd1;
      end else begin
        inicio_q <= 1'b0;
        dato_q   <= '0;
      end
    end
  end

  assign ad_out          = ad_out_q;
  assign ad_oe           = ad_oe_q;
  assign cs_n            = cs_n_q;
  assign rd_n            = rd_n_q;
  assign wr_n            = wr_n_q;
  assign ad_n            = ad_n_q;
  assign datoRTC         = dato_q;
  assign inicioSecuencia = inicio_q;
  assign datos_validos   = dv_q;
  assign bcd_err         = bcd_err_q;

endmodule

// File: tb/tb_rtc_lector.sv
// Bench for rtc_lector: T_PULSE=2, POLL_CYCLES=200, a behavioural RTC that
// latches the address on the write strobe and returns mem[addr]. Burst bytes
// are pushed into exp_q by the stimulus and popped by an independent monitor.
module tb_rtc_lector;
  logic       clk, reset, vblank;
  logic [7:0] ad_in, ad_out, datoRTC;
  logic       ad_oe, cs_n, rd_n, wr_n, ad_n, inicioSecuencia, datos_validos, bcd_err;

  rtc_lector #(.T_PULSE(2), .POLL_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .datoRTC(datoRTC), .inicioSecuencia(inicioSecuencia),
    .datos_validos(datos_validos), .bcd_err(bcd_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model
  logic [7:0] mem [0:255];
  logic [7:0] alat = 8'h00;
  always @(posedge clk) if (!cs_n && !ad_n && !wr_n && ad_oe) alat <= ad_out;
  assign ad_in = mem[alat];

  int total = 0, bad = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected byte per inicioSecuencia clock, checks length
  int run = 0;
  always @(negedge clk) begin
    if (reset) run = 0;
    else if (inicioSecuencia) begin
      run++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL burst_unexpected: got=%0d want=no burst (cyc %0d)", datoRTC, cyc);
      end else chk("burst_byte", 32'(datoRTC), 32'(exp_q.pop_front()));
    end else if (run != 0) begin
      chk("burst_len", 32'(run), 32'd14);
      chk("dato_idle", 32'(datoRTC), 32'd0);
      run = 0;
    end
    if (!rd_n) chk("rd_excl", 32'({ad_oe, wr_n}), 32'b01);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] sw1 [11], sw2 [11], sw3 [11];
  logic [12:0] rows [12];
  int e0, s, t;
  bit found;

  task automatic push_burst(input logic [7:0] v [11]);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 11; i++) exp_q.push_back(v[i]);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !inicioSecuencia) done = 1'b1;
    end
    chk("burst_drain", 32'(done), 32'd1);
  endtask

  task automatic do_burst(input logic [7:0] v [11], input bit second_edge);
    push_burst(v);
    @(posedge clk); #1 vblank = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("lat_early", 32'(inicioSecuencia), 32'd0);
    @(negedge clk); chk("lat_start", 32'(inicioSecuencia), 32'd1);
    if (second_edge) begin
      repeat (3) @(posedge clk);
      #1 vblank = 1'b0;
      @(posedge clk); #1 vblank = 1'b1;
    end
    @(posedge clk); #1 vblank = 1'b0;
    drain();
  endtask

  task automatic wait_cs_fall(output int at, output bit ok);
    bit prev = 1'b1;
    ok = 1'b0; at = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (prev && !cs_n) begin ok = 1'b1; at = cyc; end
      prev = cs_n;
    end
    chk("cs_fall_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_sig(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if ((which ? datos_validos : bcd_err) == 1'b1) ok = 1'b1;
    end
    chk(which ? "dv_seen" : "bcd_err_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h23; mem[8'h24] = 8'h31;
    mem[8'h25] = 8'h12; mem[8'h26] = 8'h17; mem[8'h27] = 8'h05; mem[8'h28] = 8'h52;
    mem[8'h41] = 8'h10; mem[8'h42] = 8'h00; mem[8'h43] = 8'h01;
    // week mask 0x3F drops bit 6: 0x52 reads back as 12
    sw1 = '{8'd45, 8'd30, 8'd23, 8'd31, 8'd12, 8'd17, 8'd5, 8'd12, 8'd10, 8'd0, 8'd1};
    sw2 = '{8'd59, 8'd30, 8'hFF, 8'd31, 8'd12, 8'd17, 8'd5, 8'd12, 8'd10, 8'd0, 8'd1};
    sw3 = '{8'd7,  8'd30, 8'd23, 8'd31, 8'd12, 8'd17, 8'd5, 8'd12, 8'd10, 8'd0, 8'hFF};
    // {cs_n, ad_n, wr_n, rd_n, ad_oe, ad_out when driven}
    rows = '{{5'b11110, 8'h00}, {5'b00111, 8'h21}, {5'b00011, 8'h21}, {5'b00011, 8'h21},
             {5'b00111, 8'h21}, {5'b11110, 8'h00}, {5'b11110, 8'h00}, {5'b01110, 8'h00},
             {5'b01100, 8'h00}, {5'b01100, 8'h00}, {5'b11110, 8'h00}, {5'b00111, 8'h22}};
    reset = 1'b1; vblank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe}), 32'b11110);
    chk("rst_ad_out", 32'(ad_out), 32'd0);
    chk("rst_burst", 32'({inicioSecuencia, datoRTC}), 32'd0);
    chk("rst_flags", 32'({datos_validos, bcd_err}), 32'd0);

    // first sweep: exact strobe waveform of index 0 and start of index 1
    @(posedge clk); #1 reset = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("wave_%0d", i),
          32'({cs_n, ad_n, wr_n, rd_n, ad_oe, ad_oe ? ad_out : 8'h00}), 32'(rows[i]));
    end

    // vblank before data is valid: no burst
    @(posedge clk); #1 vblank = 1'b1;
    repeat (3) @(posedge clk);
    #1 vblank = 1'b0;
    found = 1'b0;
    repeat (6) begin @(negedge clk); if (inicioSecuencia) found = 1'b1; end
    chk("no_early_burst", 32'(found), 32'd0);

    while (cyc < e0 + 111) @(negedge clk);
    chk("dv_before", 32'(datos_validos), 32'd0);
    @(negedge clk);
    chk("dv_after", 32'(datos_validos), 32'd1);
    chk("no_err_sweep1", 32'(bcd_err), 32'd0);

    repeat (10) @(posedge clk);
    do_burst(sw1, 1'b1);

    // sweep 2: invalid hours nibble
    mem[8'h21] = 8'h59; mem[8'h23] = 8'h9A;
    wait_cs_fall(s, found);
    wait_sig(1'b0, found);
    chk("bcd_err_time", 32'(cyc - s), 32'd111);
    @(negedge clk);
    chk("bcd_err_pulse", 32'(bcd_err), 32'd0);
    do_burst(sw2, 1'b0);

    // sweep 3: vblank edge lands on the commit clock
    mem[8'h21] = 8'h07; mem[8'h23] = 8'h23; mem[8'h43] = 8'h3F;
    wait_cs_fall(s, found);
    while (cyc < s + 110) begin @(posedge clk); #1; end
    vblank = 1'b1;
    push_burst(sw2);
    wait_sig(1'b0, found);
    chk("commit_stall", 32'(cyc - s), 32'd125);
    vblank = 1'b0;
    drain();
    do_burst(sw3, 1'b0);

    // reset during the DATA phase of index 6
    wait_cs_fall(s, found);
    while (cyc < s + 67) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_data_rd", 32'(rd_n), 32'd0);
    @(negedge clk);
    chk("rst_mid_strobes", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe}), 32'b11110);
    chk("rst_mid_dv", 32'(datos_validos), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("restart_idle", 32'(cs_n), 32'd1);
    @(negedge clk);
    chk("restart_idx0", 32'({cs_n, ad_out}), 32'({1'b0, 8'h21}));
    wait_sig(1'b1, found);
    repeat (5) @(posedge clk);
    do_burst(sw3, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
